setting_mode_controller_multi: RTL

Parametrised multi-channel key-event controller for the setting-mode path. Each of `NUM_CH` raw key inputs is synchronised, debounced and classified into press, short-press and long-press single-cycle pulses. A channel is live only while `current_mode` equals `ACTIVE_MODE` and its `ch_enable` bit is set. The block sits between the front-panel key inputs and the setting-mode FSMs and supersedes the single-channel stand-mode toggle detector.

---
 rtl/setting_mode_controller_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/setting_mode_controller_multi.sv
// Multi-channel key-event classifier for the setting-mode path: each key is
// synchronised, debounced and turned into press / short / long pulses while live.
`ifndef MODE_WIDTH
`define MODE_WIDTH 3
`endif
`ifndef STAND_MODE
`define STAND_MODE 3'd2
`endif

module setting_mode_controller_multi #(
    parameter int                    NUM_CH            = 4,
    parameter int                    MODE_WIDTH        = `MODE_WIDTH,
    parameter logic [MODE_WIDTH-1:0] ACTIVE_MODE       = `STAND_MODE,
    parameter int                    DEBOUNCE_CYCLES   = 4,
    parameter int                    LONG_PRESS_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MODE_WIDTH-1:0] current_mode,
    input  logic [NUM_CH-1:0]     ch_enable,
    input  logic [NUM_CH-1:0]     key_in,
    output logic [NUM_CH-1:0]     press_pulse,
    output logic [NUM_CH-1:0]     short_pulse,
    output logic [NUM_CH-1:0]     long_pulse,
    output logic [NUM_CH-1:0]     key_held,
    output logic                  any_event
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(LONG_PRESS_CYCLES);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} st_t;

    logic [NUM_CH-1:0] live;
    logic [NUM_CH-1:0] ev_nxt;

    assign live = (current_mode == ACTIVE_MODE) ? ch_enable : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic          s1, s2, deb;
        logic          pp, sp, lp;
        logic          press_c, short_c, long_c;
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;
        st_t           st;

        // Pulse terms shared by the lane registers and the any_event register
        always_comb begin
            press_c = live[i] && (st == IDLE) && deb;
            short_c = live[i] && (st == PRESSED) && !deb;
            long_c  = live[i] && (st == PRESSED) && deb && (hcnt == HW'(LONG_PRESS_CYCLES-1));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                deb  <= 1'b0;
                dcnt <= '0;
                hcnt <= '0;
                st   <= IDLE;
                pp   <= 1'b0;
                sp   <= 1'b0;
                lp   <= 1'b0;
            end else begin
                s1 <= key_in[i];
                s2 <= s1;
                pp <= press_c;
                sp <= short_c;
                lp <= long_c;
                if (!live[i]) begin
                    // Dropping out of live discards any event in flight
                    deb  <= 1'b0;
                    dcnt <= '0;
                    hcnt <= '0;
                    st   <= IDLE;
                end else begin
                    if (s2 == deb) begin
                        dcnt <= '0;
                    end else if (dcnt == DW'(DEBOUNCE_CYCLES-1)) begin
                        deb  <= s2;
                        dcnt <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end

                    case (st)
                        IDLE: begin
                            if (deb) begin
                                st   <= PRESSED;
                                hcnt <= '0;
                            end
                        end
                        PRESSED: begin
                            // Release takes priority over reaching the long threshold
                            if (!deb)
                                st <= IDLE;
                            else if (hcnt == HW'(LONG_PRESS_CYCLES-1))
                                st <= LONG_HELD;
                            else
                                hcnt <= hcnt + 1'b1;
                        end
                        LONG_HELD: begin
                            if (!deb)
                                st <= IDLE;
                        end
                        default: st <= IDLE;
                    endcase
                end
            end
        end

        assign press_pulse[i] = pp;
        assign short_pulse[i] = sp;
        assign long_pulse[i]  = lp;
        assign key_held[i]    = deb;
        assign ev_nxt[i]      = press_c | short_c | long_c;
    end

    always_ff @(posedge clk) begin
        if (rst)
            any_event <= 1'b0;
        else
            any_event <= |ev_nxt;
    end
endmodule
